// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer:
// operation encodings, FSM states and small decode helpers.
package muldiv_seq_pkg;

    localparam int MD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic op_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input md_op_e op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: shift-add multiply step or
// restoring divide step, sharing a single WIDTH+1 adder/subtractor.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             mode_div,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] mplr_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] mplr_out
);

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH+1:0] sum;

    always_comb begin
        rem_shift = {acc_in, mplr_in[WIDTH-1]};
        if (mode_div) begin
            add_a   = rem_shift;
            add_b   = ~{1'b0, operand};
            add_cin = 1'b1;
        end else begin
            add_a   = {1'b0, acc_in};
            add_b   = mplr_in[0] ? {1'b0, operand} : '0;
            add_cin = 1'b0;
        end

        sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};

        // In divide mode the top carry is the "no borrow" flag of the trial subtract.
        if (mode_div) begin
            if (sum[WIDTH+1]) begin
                acc_out  = sum[WIDTH-1:0];
                mplr_out = {mplr_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out  = rem_shift[WIDTH-1:0];
                mplr_out = {mplr_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out  = sum[WIDTH:1];
            mplr_out = {sum[0], mplr_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers: one
// iteration per clock on operand magnitudes, then a sign-fix/write-back edge.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             cancel,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    md_op_e           op_q, op_d;
    logic             sign1_q, sign1_d;
    logic             sign2_q, sign2_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   step_acc;
    logic [WIDTH-1:0]   step_mplr;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    md_op_e             op_in;
    logic               in1_neg;
    logic               in2_neg;
    logic [WIDTH-1:0]   in1_mag;
    logic [WIDTH-1:0]   in2_mag;

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .mode_div (op_is_div(op_q)),
        .acc_in   (acc_q),
        .mplr_in  (mplr_q),
        .operand  (opnd_q),
        .acc_out  (step_acc),
        .mplr_out (step_mplr)
    );

    always_comb begin
        op_in   = md_op_e'(op);
        in1_neg = op_is_signed(op_in) & in1[WIDTH-1];
        in2_neg = op_is_signed(op_in) & in2[WIDTH-1];
        // Negating the most-negative value leaves 2^(WIDTH-1), which is its magnitude.
        in1_mag = in1_neg ? -in1 : in1;
        in2_mag = in2_neg ? -in2 : in2;
    end

    always_comb begin
        prod_fix = (sign1_q ^ sign2_q) ? -{acc_q, mplr_q} : {acc_q, mplr_q};
        quo_fix  = (sign1_q ^ sign2_q) ? -mplr_q : mplr_q;
        rem_fix  = sign1_q ? -acc_q : acc_q;
        // With a zero divisor every trial subtract succeeds, so the remainder
        // already re-signs back to the original dividend; only LO needs forcing.
        if (opnd_q == '0) begin
            quo_fix = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        sign1_d = sign1_q;
        sign2_d = sign2_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        opnd_d  = opnd_q;
        hi_d    = hi_we ? wdata : hi_q;
        lo_d    = lo_we ? wdata : lo_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !cancel) begin
                    op_d    = op_in;
                    sign1_d = in1_neg;
                    sign2_d = in2_neg;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = RUN;
                    if (op_is_div(op_in)) begin
                        mplr_d = in1_mag;
                        opnd_d = in2_mag;
                    end else begin
                        mplr_d = in2_mag;
                        opnd_d = in1_mag;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = step_acc;
                    mplr_d  = step_mplr;
                    count_d = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d = FIX;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (op_is_div(op_q)) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            op_q    <= MD_MULTU;
            sign1_q <= 1'b0;
            sign2_q <= 1'b0;
            acc_q   <= '0;
            mplr_q  <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: transaction-level reference model,
// per-cycle compare of busy/done/hi/lo, directed vectors and random traffic.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         cancel;
    logic         hi_we;
    logic         lo_we;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [1:0]   dbg_state;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .cancel    (cancel),
        .hi_we     (hi_we),
        .lo_we     (lo_we),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic void model_calc(input logic [1:0] o, input logic [W-1:0] a,
                                       input logic [W-1:0] b,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        rh = '0;
        rl = '0;
        case (o)
            2'b00: begin
                p  = {32'b0, a} * {32'b0, b};
                rh = p[63:32];
                rl = p[31:0];
            end
            2'b01: begin
                p  = sa * sb;
                rh = p[63:32];
                rl = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    rh = a;
                    rl = '1;
                end else if (o == 2'b10) begin
                    rh = a % b;
                    rl = a / b;
                end else begin
                    q  = sa / sb;
                    r  = sa % sb;
                    rh = 32'(r);
                    rl = 32'(q);
                end
            end
        endcase
    endfunction

    bit           m_busy, m_done;
    logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
    int           m_left;

    // Transaction model: an accepted op completes W+1 edges later unless cancelled.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (hi_we) m_hi = wdata;
            if (lo_we) m_lo = wdata;
            if (m_busy) begin
                if (cancel) begin
                    m_busy = 1'b0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                        m_hi   = r_hi;
                        m_lo   = r_lo;
                    end
                end
            end else if (start && !cancel) begin
                model_calc(op, in1, in2, r_hi, r_lo);
                m_busy = 1'b1;
                m_left = W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", W'(busy), W'(m_busy));
            check("cyc_done", W'(done), W'(m_done));
            check("cyc_hi", hi, m_hi);
            check("cyc_lo", lo, m_lo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        op    = o;
        in1   = a;
        in2   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
        check("done_seen", W'(done), W'(1));
    endtask

    task automatic lit(input string name, input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
        int e;
        issue(o, a, b);
        wait_done(e);
        check({name, "_hi"}, hi, eh);
        check({name, "_lo"}, lo, el);
        check({name, "_model_hi"}, m_hi, eh);
        check({name, "_model_lo"}, m_lo, el);
        check({name, "_latency"}, W'(e), W'(33));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, busy_cnt, nd, guard;
        rst_n  = 1'b0;
        start  = 1'b0;
        cancel = 1'b0;
        hi_we  = 1'b0;
        lo_we  = 1'b0;
        op     = 2'b00;
        in1    = '0;
        in2    = '0;
        wdata  = '0;
        tick();
        chk_en = 1'b1;
        tick();
        rst_n = 1'b1;
        check("rst_busy", W'(busy), W'(0));
        check("rst_done", W'(done), W'(0));
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);

        // Latency and busy duration for the largest unsigned product.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            tick();
            lat++;
        end
        check("multu_max_latency", W'(lat), W'(33));
        check("multu_max_busy_cycles", W'(busy_cnt), W'(33));
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);

        // Each vector issues in the previous done cycle (back-to-back acceptance).
        lit("mult_neg3x5", 2'b01, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        lit("mult_minxmin", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        lit("divu_7_2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3);
        lit("div_n7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        lit("div_7_n2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
        lit("divu_5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
        lit("div_n5_0", 2'b11, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
        lit("div_min_n1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // A second start during RUN is dropped.
        issue(2'b00, 32'd2, 32'd3);
        repeat (4) tick();
        op = 2'b00; in1 = 32'd100; in2 = 32'd100; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("ignored_start_lo", lo, 32'd6);
        nd = 0;
        repeat (40) begin tick(); if (done) nd++; end
        check("ignored_start_no_second_done", W'(nd), W'(0));

        // Cancel mid-RUN keeps the MTHI/MTLO values.
        hi_we = 1'b1; wdata = 32'hAAAA_0001; tick(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h5555_0002; tick(); lo_we = 1'b0;
        issue(2'b10, 32'd1000, 32'd7);
        repeat (9) tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", W'(busy), W'(0));
        nd = 0;
        repeat (40) begin tick(); if (done) nd++; end
        check("cancel_no_done", W'(nd), W'(0));
        check("cancel_hi", hi, 32'hAAAA_0001);
        check("cancel_lo", lo, 32'h5555_0002);

        // Reset in the middle of an op.
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_done", W'(done), W'(0));
        check("midrst_hi", hi, '0);
        check("midrst_lo", lo, '0);

        // MTHI on the completion edge loses to the result.
        issue(2'b00, 32'd3, 32'd4);
        repeat (32) tick();
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        hi_we = 1'b0;
        check("fix_vs_mthi_done", W'(done), W'(1));
        check("fix_vs_mthi_hi", hi, 32'h0);
        check("fix_vs_mthi_lo", lo, 32'd12);

        // Random traffic with stray MTHI/MTLO, ignored starts and occasional cancels.
        repeat (60) begin
            issue(2'($urandom_range(0, 3)), pick_operand(), pick_operand());
            guard = 0;
            while (busy && guard < 50) begin
                hi_we  = ($urandom_range(0, 7) == 0);
                lo_we  = ($urandom_range(0, 7) == 0);
                wdata  = $urandom;
                start  = ($urandom_range(0, 7) == 0);
                in1    = $urandom;
                cancel = ($urandom_range(0, 63) == 0);
                tick();
                guard++;
            end
            check("rand_drain", W'(busy), W'(0));
            hi_we  = 1'b0;
            lo_we  = 1'b0;
            start  = 1'b0;
            cancel = 1'b0;
        end
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
